serial_word_rx: RTL and testbench

Serial-to-parallel receiver for the framed serial stream produced by the team's parallel-access shift register transmitter. It detects a start bit, shifts in N data bits LSB-first, checks a stop bit and places the word in a one-entry holding register. The holding register is drained by a valid/ready handshake, so a new frame can be received while the previous word waits for the consumer.

---
 rtl/serial_word_rx_pkg.sv | 13 +
 rtl/rx_hold_buf.sv | 36 +++
 rtl/serial_word_rx.sv | 99 +++++++++
 tb/tb_serial_word_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_rx_pkg.sv
// Shared definitions for the framed serial word receiver:
// FSM state encoding and the idle level of the serial line.
package serial_word_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } rx_state_e;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/rx_hold_buf.sv
// One-entry holding register with valid/ready drain. A load in the same
// cycle as a drain replaces the word and keeps valid asserted.
module rx_hold_buf #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         data_ready,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    output logic         full_block
);

    logic [N-1:0] r_data;
    logic         r_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= load_data;
            r_valid <= 1'b1;
        end else if (r_valid && data_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Full and not being drained this cycle: a completed word has nowhere to go.
    assign full_block = r_valid && !data_ready;
    assign data_out   = r_data;
    assign data_valid = r_valid;

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel receiver: start bit, N data bits LSB-first, stop bit,
// word handed to a one-entry holding register drained by valid/ready.
module serial_word_rx
    import serial_word_rx_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         serial_in,
    input  logic         sample_en,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    input  logic         data_ready,
    output logic         busy,
    output logic         overrun,
    output logic         frame_err
);

    localparam int CW = $clog2(N);

    rx_state_e     r_state;
    logic [N-1:0]  r_shreg;
    logic [CW-1:0] r_bit_cnt;
    logic          r_busy;
    logic          r_overrun;
    logic          r_frame_err;

    logic w_full_block;
    logic w_load;

    assign w_load = sample_en && (r_state == STOP) && (serial_in == LINE_IDLE) && !w_full_block;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            if (sample_en) begin
                case (r_state)
                    IDLE: begin
                        if (serial_in != LINE_IDLE) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                            r_busy    <= 1'b1;
                        end
                    end
                    DATA: begin
                        r_shreg <= {serial_in, r_shreg[N-1:1]};
                        if (r_bit_cnt == CW'(N - 1)) begin
                            r_state   <= STOP;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        // A good frame that cannot load is dropped and flagged.
                        if (serial_in == LINE_IDLE) begin
                            r_overrun <= w_full_block;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    rx_hold_buf #(
        .N(N)
    ) u_hold (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (w_load),
        .load_data  (r_shreg),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .full_block (w_full_block)
    );

    assign busy      = r_busy;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_serial_word_rx.sv
// Randomized scoreboard bench for serial_word_rx (N=4): a frame-level
// reference model feeds expectation queues that a negedge monitor consumes.
module tb_serial_word_rx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       serial_in = 1'b1;
    logic       sample_en = 1'b0;
    logic [3:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b0;
    logic       busy;
    logic       overrun;
    logic       frame_err;

    serial_word_rx #(.N(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .serial_in  (serial_in),
        .sample_en  (sample_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // scoreboard
    logic [3:0] word_q[$];
    int         ovr_q[$];
    int         fe_q[$];
    bit         exp_valid[int];
    logic [3:0] exp_data[int];
    bit         exp_busy[int];

    // reference model state
    bit         in_frame = 0;
    int         nbits = 0;
    logic [3:0] word_m = '0;
    bit         valid_m = 0;
    logic [3:0] hold_m = '0;

    int rdy_mode = 1;    // 0 low, 1 high, 2 random
    int force_rdy = -1;

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (exp_valid.exists(cyc)) begin
                chk("data_valid", int'(data_valid), int'(exp_valid[cyc]));
                chk("busy", int'(busy), int'(exp_busy[cyc]));
                if (exp_valid[cyc]) chk("held_data", int'(data_out), int'(exp_data[cyc]));
            end
            if (data_valid && data_ready) begin
                if (word_q.size() == 0) chk("unexpected_read", 1, 0);
                else chk("read_word", int'(data_out), int'(word_q.pop_front()));
            end
            while (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
                chk("missing_overrun", 0, 1);
                void'(ovr_q.pop_front());
            end
            while (fe_q.size() > 0 && fe_q[0] < cyc) begin
                chk("missing_frame_err", 0, 1);
                void'(fe_q.pop_front());
            end
            if (ovr_q.size() > 0 && ovr_q[0] == cyc) begin
                chk("overrun_pulse", int'(overrun), 1);
                void'(ovr_q.pop_front());
            end else if (overrun) begin
                chk("spurious_overrun", 1, 0);
            end
            if (fe_q.size() > 0 && fe_q[0] == cyc) begin
                chk("frame_err_pulse", int'(frame_err), 1);
                void'(fe_q.pop_front());
            end else if (frame_err) begin
                chk("spurious_frame_err", 1, 0);
            end
        end
    end

    // One clock cycle of stimulus plus the model's view of what it causes.
    task automatic cycle(input bit se, input bit sin);
        bit r, good, drain, load;
        case (rdy_mode)
            0:       r = 1'b0;
            1:       r = 1'b1;
            default: r = bit'($urandom_range(1, 0));
        endcase
        if (force_rdy >= 0) r = (force_rdy != 0);
        sample_en  = se;
        serial_in  = sin;
        data_ready = r;
        good = 0;
        if (se) begin
            if (!in_frame) begin
                if (!sin) begin
                    in_frame = 1;
                    nbits    = 0;
                    word_m   = '0;
                end
            end else if (nbits < 4) begin
                word_m[nbits[1:0]] = sin;
                nbits++;
            end else begin
                in_frame = 0;
                if (sin) good = 1;
                else fe_q.push_back(cyc + 1);
            end
        end
        drain = valid_m && r;
        load  = good && (!valid_m || drain);
        if (good && !load) ovr_q.push_back(cyc + 1);
        if (load) begin
            hold_m  = word_m;
            valid_m = 1;
            word_q.push_back(word_m);
        end else if (drain) begin
            valid_m = 0;
        end
        exp_valid[cyc + 1] = valid_m;
        exp_data[cyc + 1]  = hold_m;
        exp_busy[cyc + 1]  = in_frame;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [3:0] w, input bit stop, input int gmin,
                              input int gmax, input int stop_rdy);
        logic [5:0] fr;
        int g;
        fr = {stop, w, 1'b0};
        for (int i = 0; i < 6; i++) begin
            if (i == 5) force_rdy = stop_rdy;
            cycle(1'b1, fr[i]);
            force_rdy = -1;
            g = int'($urandom_range(gmax, gmin));
            repeat (g) cycle(1'b0, fr[i]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, 1'b1);
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        sample_en  = 1'b0;
        serial_in  = 1'b1;
        data_ready = 1'b0;
        #1;
        chk("reset_outputs", int'({data_out, data_valid, busy, overrun, frame_err}), 0);
        in_frame = 0;
        nbits    = 0;
        valid_m  = 0;
        hold_m   = '0;
        word_q.delete();
        ovr_q.delete();
        fe_q.delete();
        exp_valid.delete();
        exp_data.delete();
        exp_busy.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();

        // single frame, consumer always ready
        rdy_mode = 1;
        send_frame(4'hB, 1'b1, 1, 1, -1);
        idle(4);

        // back-pressure: second frame overruns, then drain
        rdy_mode = 0;
        send_frame(4'hB, 1'b1, 1, 1, -1);
        send_frame(4'h6, 1'b1, 1, 1, -1);
        idle(3);
        rdy_mode = 1;
        idle(4);

        // drain and load in the same cycle as the stop-bit sample
        rdy_mode = 0;
        send_frame(4'hB, 1'b1, 1, 1, -1);
        send_frame(4'h6, 1'b1, 1, 1, 1);
        idle(3);
        rdy_mode = 1;
        idle(3);

        // framing error followed directly by a good frame
        send_frame(4'h5, 1'b0, 1, 1, -1);
        send_frame(4'h3, 1'b1, 1, 1, -1);
        idle(3);

        // reset after two data bits
        cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b1); cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
        do_reset();
        send_frame(4'h9, 1'b1, 1, 1, -1);
        idle(3);

        // idle line, then a frame with irregular strobe gaps
        repeat (10) begin
            cycle(1'b1, 1'b1);
            cycle(1'b0, 1'b1);
        end
        send_frame(4'hA, 1'b1, 1, 3, -1);
        idle(3);

        // randomized traffic with random back-pressure and stop errors
        rdy_mode = 2;
        for (int f = 0; f < 80; f++) begin
            send_frame(4'($urandom), ($urandom_range(7, 0) != 0), 0, 3, -1);
            if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(3, 1)));
        end
        rdy_mode = 1;
        idle(6);

        chk("words_left", word_q.size(), 0);
        chk("overruns_left", ovr_q.size(), 0);
        chk("frame_errs_left", fe_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
